// File: rtl/bit_scan16_pkg.sv
// rtl/bit_scan16_pkg.sv - shared constants, state encoding and popcount helper for bit_scan16
package bit_scan16_pkg;

    localparam int BS_WIDTH = 16;
    localparam int BS_IDX_W = 4;
    localparam int BS_CNT_W = 5;

    typedef enum logic {
        BS_IDLE = 1'b0,
        BS_SCAN = 1'b1
    } bs_state_t;

    function automatic logic [BS_CNT_W-1:0] bs_popcount(input logic [BS_WIDTH-1:0] m);
        logic [BS_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BS_WIDTH; i++) begin
            cnt = cnt + {{(BS_CNT_W-1){1'b0}}, m[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bit_scan16_pe16.sv
// rtl/bit_scan16_pe16.sv - combinational lowest-set-bit priority encoder (module pe16)
module pe16
    import bit_scan16_pkg::*;
(
    input  logic [BS_WIDTH-1:0] mask,
    output logic [BS_IDX_W-1:0] idx,
    output logic                valid
);

    // Walking from the top down lets the lowest set bit win the last assignment.
    always_comb begin
        idx = '0;
        for (int i = BS_WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = BS_IDX_W'(i);
            end
        end
    end

    assign valid = |mask;

endmodule

// File: rtl/bit_scan16.sv
// rtl/bit_scan16.sv - sequential set-bit index scanner; popcount port under BIT_SCAN16_COUNT_EN
module bit_scan16
    import bit_scan16_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BS_WIDTH-1:0] in_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BS_IDX_W-1:0] out_idx,
    output logic                out_last,
    output logic                out_none,
`ifdef BIT_SCAN16_COUNT_EN
    output logic [BS_CNT_W-1:0] out_count,
`endif
    output logic                out_any
);

    bs_state_t           state;
    logic [BS_WIDTH-1:0] mask_q;
    logic                any_q;
    logic [BS_IDX_W-1:0] pe_idx;
    logic                pe_valid;
    logic                single;
    logic                in_fire;
    logic                out_fire;

    pe16 u_pe16 (
        .mask  (mask_q),
        .idx   (pe_idx),
        .valid (pe_valid)
    );

    // True for zero or exactly one set bit; the zero case is the lone none-beat.
    assign single    = (mask_q & (mask_q - BS_WIDTH'(1))) == '0;

    assign in_ready  = (state == BS_IDLE);
    assign out_valid = (state == BS_SCAN);
    assign out_idx   = pe_idx;
    assign out_last  = out_valid & single;
    assign out_none  = out_valid & ~pe_valid;
    assign out_any   = any_q;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= BS_IDLE;
            mask_q <= '0;
            any_q  <= 1'b0;
        end else begin
            case (state)
                BS_IDLE: begin
                    if (in_fire) begin
                        mask_q <= in_mask;
                        any_q  <= |in_mask;
                        state  <= BS_SCAN;
                    end
                end
                BS_SCAN: begin
                    if (out_fire) begin
                        mask_q <= mask_q & (mask_q - BS_WIDTH'(1));
                        if (single) begin
                            state <= BS_IDLE;
                        end
                    end
                end
                default: state <= BS_IDLE;
            endcase
        end
    end

`ifdef BIT_SCAN16_COUNT_EN
    logic [BS_CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (in_fire) begin
            count_q <= bs_popcount(in_mask);
        end
    end

    assign out_count = count_q;
`endif

endmodule
